// File: rtl/sfs_pkg.sv
// rtl/sfs_pkg.sv - shared state encoding and field widths for the serial frame scheduler
package sfs_pkg;
   localparam int N_REQ  = 4;
   localparam int PORT_W = 2;
   localparam int CNT_W  = 4;
   localparam int DATA_W = 15;

   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      PORT  = 3'd2,
      COUNT = 3'd3,
      DATA  = 3'd4,
      GAP   = 3'd5
   } state_t;
endpackage

// File: rtl/serial_frame_scheduler_arb.sv
// rtl/serial_frame_scheduler_arb.sv - combinational round-robin select over four requesters
module rr_arbiter_4
   import sfs_pkg::*;
(
   input  logic [3:0] i_req,
   input  logic [1:0] i_ptr,
   output logic [3:0] o_grant,
   output logic [1:0] o_idx
);

   logic [1:0] w_cand;

   // Scan from farthest to nearest so the candidate closest to the pointer wins.
   always_comb begin
      o_grant = 4'b0000;
      o_idx   = i_ptr;
      w_cand  = i_ptr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_cand = i_ptr + k[1:0];
         if (i_req[w_cand]) begin
            o_grant = 4'b0001 << w_cand;
            o_idx   = w_cand;
         end
      end
   end

endmodule

// File: rtl/serial_frame_scheduler.sv
// rtl/serial_frame_scheduler.sv - builds start/port/count/payload frames and shifts them onto one serial line
module serial_frame_scheduler
   import sfs_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        Clk_EN,
   input  logic [3:0]  req,
   input  logic [15:0] cnt_in,
   input  logic [59:0] data_in,
   output logic [3:0]  grant,
   output logic        serOut,
   output logic        busy,
   output logic [1:0]  cur_port,
   output logic        frame_done
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_ser;
   logic                w_ser_nxt;
   logic [3:0]          r_bit;
   logic [3:0]          w_bit_nxt;
   logic [3:0]          w_bit_dec;
   logic [3:0]          w_cnt_dec;
   logic [1:0]          r_port;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_data;
   logic                r_busy;
   logic                w_busy_nxt;
   logic [1:0]          r_rr_ptr;
   logic                w_last;
   logic                w_accept;
   logic [3:0]          w_arb_grant;
   logic [1:0]          w_arb_idx;
   logic [CNT_W-1:0]    w_cnt_arr  [N_REQ];
   logic [DATA_W-1:0]   w_data_arr [N_REQ];

   rr_arbiter_4 u_arb (
      .i_req   (req),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx)
   );

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         w_cnt_arr[i]  = cnt_in[CNT_W*i +: CNT_W];
         w_data_arr[i] = data_in[DATA_W*i +: DATA_W];
      end
   end

   assign w_accept  = Clk_EN && (r_state == IDLE) && (req != 4'b0000);
   assign w_bit_dec = r_bit - 4'd1;
   assign w_cnt_dec = r_cnt - 4'd1;

   // r_bit indexes the bit currently on the line; each field reloads it on entry.
   always_comb begin
      w_state_nxt = r_state;
      w_ser_nxt   = r_ser;
      w_bit_nxt   = r_bit;
      w_busy_nxt  = r_busy;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            w_ser_nxt = IDLE_LEVEL;
            if (req != 4'b0000) begin
               w_state_nxt = START;
               w_ser_nxt   = 1'b0;
               w_busy_nxt  = 1'b1;
            end
         end
         START: begin
            w_state_nxt = PORT;
            w_bit_nxt   = 4'(PORT_W - 1);
            w_ser_nxt   = r_port[PORT_W-1];
         end
         PORT: begin
            if (r_bit == 4'd0) begin
               w_state_nxt = COUNT;
               w_bit_nxt   = 4'(CNT_W - 1);
               w_ser_nxt   = r_cnt[CNT_W-1];
            end else begin
               w_bit_nxt = w_bit_dec;
               w_ser_nxt = r_port[w_bit_dec[0]];
            end
         end
         COUNT: begin
            if (r_bit == 4'd0) begin
               if (r_cnt != '0) begin
                  w_state_nxt = DATA;
                  w_bit_nxt   = w_cnt_dec;
                  w_ser_nxt   = r_data[w_cnt_dec];
               end else begin
                  w_state_nxt = GAP;
                  w_ser_nxt   = IDLE_LEVEL;
                  w_last      = 1'b1;
               end
            end else begin
               w_bit_nxt = w_bit_dec;
               w_ser_nxt = r_cnt[w_bit_dec[1:0]];
            end
         end
         DATA: begin
            if (r_bit == 4'd0) begin
               w_state_nxt = GAP;
               w_ser_nxt   = IDLE_LEVEL;
               w_last      = 1'b1;
            end else begin
               w_bit_nxt = w_bit_dec;
               w_ser_nxt = r_data[w_bit_dec];
            end
         end
         GAP: begin
            w_state_nxt = IDLE;
            w_ser_nxt   = IDLE_LEVEL;
            w_busy_nxt  = 1'b0;
         end
         default: begin
            w_state_nxt = IDLE;
            w_ser_nxt   = IDLE_LEVEL;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_ser    <= IDLE_LEVEL;
         r_bit    <= 4'd0;
         r_port   <= 2'd0;
         r_cnt    <= '0;
         r_data   <= '0;
         r_busy   <= 1'b0;
         r_rr_ptr <= 2'd0;
      end else if (Clk_EN) begin
         r_state <= w_state_nxt;
         r_ser   <= w_ser_nxt;
         r_bit   <= w_bit_nxt;
         r_busy  <= w_busy_nxt;
         if (w_accept) begin
            r_port   <= w_arb_idx;
            r_cnt    <= w_cnt_arr[w_arb_idx];
            r_data   <= w_data_arr[w_arb_idx];
            r_rr_ptr <= w_arb_idx + 2'd1;
         end
      end
   end

   assign grant      = w_accept ? w_arb_grant : 4'b0000;
   assign frame_done = Clk_EN & w_last;
   assign serOut     = r_ser;
   assign busy       = r_busy;
   assign cur_port   = r_port;

endmodule

// File: tb/tb_serial_frame_scheduler.sv
// tb/tb_serial_frame_scheduler.sv - scoreboard bench for serial_frame_scheduler
module tb_serial_frame_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        Clk_EN;
   logic [3:0]  req;
   logic [15:0] cnt_in;
   logic [59:0] data_in;
   logic [3:0]  grant;
   logic        serOut;
   logic        busy;
   logic [1:0]  cur_port;
   logic        frame_done;

   serial_frame_scheduler dut (
      .clk        (clk),
      .rst        (rst),
      .Clk_EN     (Clk_EN),
      .req        (req),
      .cnt_in     (cnt_in),
      .data_in    (data_in),
      .grant      (grant),
      .serOut     (serOut),
      .busy       (busy),
      .cur_port   (cur_port),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  grant;
      logic [1:0]  port;
      int          len;
      logic [31:0] bits;
      int          fd;
      int          spacing;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;

   int n_vec  = 0;
   int n_miss = 0;

   int          mon_grants = 0;
   bit          mon_active = 0;
   bit          check_idle = 0;
   bit          held_v     = 0;
   logic        held;
   logic [31:0] col;
   int          idx;
   int          fd_seen;
   int          busy_lo;
   int          en_cyc = 0;
   int          last_grant_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic push(input logic [3:0] g, input logic [1:0] p, input int len,
                       input logic [31:0] bits, input int fd, input int sp);
      exp_t e;
      e.grant = g; e.port = p; e.len = len; e.bits = bits; e.fd = fd; e.spacing = sp;
      exp_q.push_back(e);
   endtask

   task automatic set_port(input int p, input logic [3:0] c, input logic [14:0] d);
      cnt_in[4*p +: 4]   = c;
      data_in[15*p +: 15] = d;
   endtask

   task automatic wait_grants(input int target);
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (mon_grants >= target) begin ok = 1; break; end
      end
      if (!ok) chk("grant_timeout", mon_grants, target);
   endtask

   task automatic wait_done();
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && !mon_active && !check_idle) begin ok = 1; break; end
      end
      if (!ok) chk("done_timeout", exp_q.size(), 0);
   endtask

   // Monitor: one serial bit per enabled cycle, compared against the popped frame.
   always @(negedge clk) begin
      if (rst) begin
         mon_active = 0;
         check_idle = 0;
         held_v     = 0;
      end else if (!Clk_EN) begin
         chk("grant_gated", grant, 0);
         chk("done_gated", frame_done, 0);
         if (mon_active) begin held = serOut; held_v = 1; end
      end else begin
         if (mon_active) begin
            if (held_v) chk("bit_hold", serOut, held);
            held_v = 0;
            if (grant != 4'b0000) chk("grant_while_busy", grant, 0);
            col = {col[30:0], serOut};
            if (frame_done) fd_seen = idx;
            if (!busy) busy_lo++;
            idx++;
            if (idx == cur.len) begin
               chk("frame_bits", col, cur.bits);
               chk("frame_done_pos", fd_seen, cur.fd);
               chk("busy_during_frame", busy_lo, 0);
               chk("cur_port", cur_port, cur.port);
               mon_active = 0;
               check_idle = 1;
            end
         end else begin
            if (frame_done) chk("stray_frame_done", 1, 0);
            if (check_idle) begin
               chk("busy_clear", busy, 0);
               chk("idle_level", serOut, 1);
               check_idle = 0;
            end
            if (grant != 4'b0000) begin
               mon_grants++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_grant", grant, 0);
               end else begin
                  cur = exp_q.pop_front();
                  chk("grant", grant, cur.grant);
                  if (cur.spacing > 0) chk("grant_spacing", en_cyc - last_grant_cyc, cur.spacing);
                  last_grant_cyc = en_cyc;
                  mon_active = 1;
                  idx = 0;
                  col = 0;
                  fd_seen = -1;
                  busy_lo = 0;
               end
            end
         end
         en_cyc++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0;
      rst = 1'b1; Clk_EN = 1'b1; req = 4'b0000; cnt_in = '0; data_in = '0;
      #23;
      chk("rst_serOut", serOut, 1);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_cur_port", cur_port, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Round robin, all ports requesting with cnt=1
      set_port(0, 4'd1, 15'h0001);
      set_port(1, 4'd1, 15'h7ffe);
      set_port(2, 4'd1, 15'h5555);
      set_port(3, 4'd1, 15'h2aaa);
      push(4'b0001, 2'd0, 9, 32'b000000111, 7, 0);
      push(4'b0010, 2'd1, 9, 32'b001000101, 7, 10);
      push(4'b0100, 2'd2, 9, 32'b010000111, 7, 10);
      push(4'b1000, 2'd3, 9, 32'b011000101, 7, 10);
      push(4'b0001, 2'd0, 9, 32'b000000111, 7, 10);
      g0 = mon_grants;
      req = 4'b1111;
      wait_grants(g0 + 5);
      req = 4'b0000;
      wait_done();

      // Single request, port 2, cnt=3, data=101
      set_port(2, 4'd3, 15'b101);
      push(4'b0100, 2'd2, 11, 32'b01000111011, 9, 0);
      g0 = mon_grants;
      req = 4'b0100;
      wait_grants(g0 + 1);
      req = 4'b0000;
      wait_done();

      // Zero-length frame on port 0
      set_port(0, 4'd0, 15'h7fff);
      push(4'b0001, 2'd0, 8, 32'b00000001, 6, 0);
      g0 = mon_grants;
      req = 4'b0001;
      wait_grants(g0 + 1);
      req = 4'b0000;
      wait_done();

      // Clock enable toggling during a port-1 frame
      set_port(1, 4'd5, 15'b10110);
      push(4'b0010, 2'd1, 13, 32'b0010101101101, 11, 0);
      g0 = mon_grants;
      req = 4'b0010;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         Clk_EN = ~Clk_EN;
         if (mon_grants > g0) req = 4'b0000;
         if (mon_grants > g0 && exp_q.size() == 0 && !mon_active) break;
      end
      Clk_EN = 1'b1;
      wait_done();
      chk("en_grant_count", mon_grants, g0 + 1);

      // Late req/data change one cycle after grant
      set_port(0, 4'd4, 15'b1001);
      push(4'b0001, 2'd0, 12, 32'b000010010011, 10, 0);
      g0 = mon_grants;
      req = 4'b0001;
      wait_grants(g0 + 1);
      @(posedge clk); #1;
      req = 4'b0000;
      set_port(0, 4'd15, 15'b0110);
      wait_done();
      chk("late_grant_count", mon_grants, g0 + 1);

      // Reset during DATA, then port 3 alone
      set_port(1, 4'd8, 15'h00ff);
      push(4'b0010, 2'd1, 16, 32'h0, 0, 0);
      g0 = mon_grants;
      req = 4'b0010;
      wait_grants(g0 + 1);
      req = 4'b0000;
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_serOut", serOut, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_cur_port", cur_port, 0);
      @(posedge clk); #1 rst = 1'b0;
      set_port(3, 4'd2, 15'b10);
      push(4'b1000, 2'd3, 10, 32'b0110010101, 8, 0);
      g0 = mon_grants;
      req = 4'b1000;
      wait_grants(g0 + 1);
      req = 4'b0000;
      wait_done();

      chk("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/serial_frame_scheduler.md
Name: serial_frame_scheduler

Overview:
Shares one serial link between four parallel requesters. It builds frames in the lab's serial protocol and drives them bit by bit onto the serIn input of the downstream serial receiver FSM: start bit 0, 2-bit port id, 4-bit count, then count payload bits. Arbitration is round-robin. All sequencing advances only on Clk_EN, so the block stays in lockstep with the receiver it feeds.

Parameters:
N_REQ, 4, number of requesters; fixed at 4 because the port-id field is 2 bits.
CNT_W, 4, width of the count field; maximum payload is 15 bits.
DATA_W, 15, payload register width per requester; equals 2^CNT_W-1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
Clk_EN  input  1  clock enable; state advances only on edges where Clk_EN=1.
req  input  4  request per port; level-sensitive.
cnt_in  input  16  payload length per port; port i uses bits [4i+3:4i].
data_in  input  60  payload per port; port i uses bits [15i+14:15i], LSB-aligned.
grant  output  4  one-hot acknowledge, one clk wide, on the accepting enabled edge.
serOut  output  1  serial line to the receiver's serIn; idle value 1.
busy  output  1  high from grant until the end of the gap bit.
cur_port  output  2  index of the port in service; holds the last served port when idle.
frame_done  output  1  one clk wide pulse on the edge that sends the last frame bit.

Behaviour:
- Reset (async, immediate, also mid-frame; the frame is abandoned with no retry): state=IDLE, serOut=1, grant=0, busy=0, frame_done=0, cur_port=0, rr_ptr=0.
- Clk_EN=0: all registers hold and grant/frame_done read 0. Each frame bit lasts exactly one enabled cycle.
- States: IDLE, START, PORT, COUNT, DATA, GAP. serOut is registered and reflects the bit of the current state.
- IDLE: serOut=1. On an enabled edge with req!=0:
  - select the first requesting index at or above rr_ptr, wrapping;
  - latch the selected port's cnt and data; set cur_port; pulse grant; set busy; set rr_ptr=(sel+1) mod 4;
  - go to START.
- START: serOut=0 for one bit -> PORT.
- PORT: cur_port, MSB first, 2 bits -> COUNT.
- COUNT: latched cnt, MSB first, 4 bits.
  - cnt!=0 -> DATA.
  - cnt==0 -> GAP; frame_done pulses on the edge leaving the count LSB.
- DATA: latched data bits [cnt-1] down to [0]. Bits above cnt-1 are ignored. frame_done pulses with the final bit -> GAP.
- GAP: serOut=1 for one bit (mandatory inter-frame idle) -> IDLE; busy clears on leaving GAP.
- Frame length is 7+cnt bits plus 1 gap bit. Grant-to-next-grant minimum is 9+cnt enabled cycles, because IDLE consumes one enabled cycle before the next arbitration.
- req changes after grant have no effect on the frame in flight. A req held high is re-arbitrated on a later IDLE pass.
- cnt_in/data_in are sampled only on the grant edge.
- Bit counter is 4 bits and never wraps: it reloads on each field entry.

Decomposition:
- Package sfs_pkg holds:
  - state encoding constants: IDLE, START, PORT, COUNT, DATA, GAP;
  - field widths: PORT_W=2, CNT_W=4;
  - IDLE_LEVEL=1.
- One sub-module, rr_arbiter_4: combinational select from req and rr_ptr, producing a one-hot grant and a 2-bit index. The pointer register stays in the parent.

Test Plan:
- Single request: Clk_EN=1, req=4'b0100, cnt[2]=3, data[2]=15'b101 -> after grant, serOut=0,1,0,0,0,1,1,1,0,1 then gap 1. frame_done pulses with the last 1; busy is high for 11 cycles.
- Zero-length frame: req=4'b0001, cnt[0]=0 -> serOut=0,0,0,0,0,0,0 then 1. frame_done pulses on the count LSB; no DATA state is entered.
- Round robin: req=4'b1111 held, all cnt=1 -> grant order 0001, 0010, 0100, 1000, 0001. Successive grants are 10 enabled cycles apart.
- Clock enable: Clk_EN toggles 1,0,1,0 during a port-1 frame -> serOut bit sequence matches the Clk_EN=1 run. Each bit lasts 2 clk; grant and frame_done each appear once, one clk wide.
- Reset mid-frame: assert rst during DATA -> in the same cycle serOut=1, busy=0, cur_port=0. After release with req=4'b1000 the grant goes to port 3, because rr_ptr was reset to 0 and port 3 is the only requester.
- Late req change: drop req and change data_in one cycle after grant -> the frame still carries the latched values. There is no second grant while busy=1.
